// File: rtl/gen_delta_div.sv
// Runtime slope generator: delta = y / x as fixed-point DT_I.DT_D, computed by an
// iterative restoring divider (one quotient bit per clock) behind valid/ready handshakes.
module gen_delta_div #(
  parameter int DSIZE  = 16,
  parameter int DT_I   = 8,
  parameter int DT_D   = 4,
  parameter int SIGNED = 0
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DSIZE-1:0]       x_displacement,
  input  logic [DSIZE-1:0]       y_displacement,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DT_I+DT_D-1:0]   delta,
  output logic                   sat,
  output logic                   div0,
  output logic [1:0]             dbg_state
);

  localparam int W  = DT_I + DT_D;
  localparam int N  = DSIZE + DT_D;
  localparam int CW = $clog2(N + 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid and the result stay stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [DSIZE-1:0] x_q, x_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [DSIZE-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             yzero_q, yzero_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     delta_q, delta_d;
  logic             sat_q, sat_d;
  logic             div0_q, div0_d;

  logic [DSIZE:0]   rem_sh;
  logic             ge;
  logic [DSIZE-1:0] mag;
  logic [W-1:0]     mag_max;
  logic [W-1:0]     m;
  logic             ovf;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    yzero_d     = yzero_q;
    out_valid_d = out_valid_q;
    delta_d     = delta_q;
    sat_d       = sat_q;
    div0_d      = div0_q;

    rem_sh  = {rem_q, quo_q[N-1]};
    ge      = rem_sh >= {1'b0, x_q};
    mag     = y_displacement;
    m       = '0;
    ovf     = 1'b0;
    mag_max = (SIGNED != 0) ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_d   = (SIGNED != 0) && y_displacement[DSIZE-1];
          mag     = neg_d ? (~y_displacement + 1'b1) : y_displacement;
          x_d     = x_displacement;
          quo_d   = N'(mag) << DT_D;
          rem_d   = '0;
          cnt_d   = '0;
          yzero_d = (y_displacement == '0);
          state_d = (x_displacement == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        rem_d = ge ? DSIZE'(rem_sh - {1'b0, x_q}) : rem_sh[DSIZE-1:0];
        quo_d = {quo_q[N-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle publishes the clamped, signed result; later cycles wait to retire.
        if (!out_valid_q) begin
          if (x_q == '0) begin
            div0_d = 1'b1;
            sat_d  = !yzero_q;
            m      = yzero_q ? '0 : mag_max;
          end else begin
            div0_d = 1'b0;
            ovf    = (SIGNED != 0) ? ((quo_q >> (W - 1)) != '0) : ((quo_q >> W) != '0);
            sat_d  = ovf;
            m      = ovf ? mag_max : W'(quo_q);
          end
          delta_d     = neg_q ? (~m + 1'b1) : m;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      yzero_q     <= 1'b0;
      out_valid_q <= 1'b0;
      delta_q     <= '0;
      sat_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      yzero_q     <= yzero_d;
      out_valid_q <= out_valid_d;
      delta_q     <= delta_d;
      sat_q       <= sat_d;
      div0_q      <= div0_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign delta     = delta_q;
  assign sat       = sat_q;
  assign div0      = div0_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gen_delta_div.sv
// Directed bench for gen_delta_div: one unsigned and one signed instance share the
// operand buses; sel picks which instance a transaction targets.
module tb_gen_delta_div;

  localparam int DSIZE = 16;
  localparam int W     = 12;

  logic             clock;
  logic             rst_n;
  logic             sel;
  logic             in_valid;
  logic             out_ready;
  logic [DSIZE-1:0] x_i, y_i;

  logic             in_valid_u, in_valid_s, out_ready_u, out_ready_s;
  logic             in_ready_u, in_ready_s, out_valid_u, out_valid_s;
  logic [W-1:0]     delta_u, delta_s;
  logic             sat_u, sat_s, div0_u, div0_s;
  logic [1:0]       state_u, state_s;

  logic             in_ready, out_valid, sat, div0;
  logic [W-1:0]     delta;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];

  assign in_valid_u  = in_valid & !sel;
  assign in_valid_s  = in_valid & sel;
  assign out_ready_u = out_ready & !sel;
  assign out_ready_s = out_ready & sel;
  assign in_ready    = sel ? in_ready_s  : in_ready_u;
  assign out_valid   = sel ? out_valid_s : out_valid_u;
  assign delta       = sel ? delta_s     : delta_u;
  assign sat         = sel ? sat_s       : sat_u;
  assign div0        = sel ? div0_s      : div0_u;
  assign state       = sel ? state_s     : state_u;

  gen_delta_div #(.DSIZE(16), .DT_I(8), .DT_D(4), .SIGNED(0)) u_dut_u (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid_u), .in_ready(in_ready_u),
    .x_displacement(x_i), .y_displacement(y_i), .out_valid(out_valid_u),
    .out_ready(out_ready_u), .delta(delta_u), .sat(sat_u), .div0(div0_u),
    .dbg_state(state_u)
  );

  gen_delta_div #(.DSIZE(16), .DT_I(8), .DT_D(4), .SIGNED(1)) u_dut_s (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .x_displacement(x_i), .y_displacement(y_i), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .delta(delta_s), .sat(sat_s), .div0(div0_s),
    .dbg_state(state_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operand pair and wait for the result; leaves the result pending.
  task automatic issue(input bit s, input logic [15:0] y, input logic [15:0] x,
                       input logic [W-1:0] ed, input bit es, input bit ez,
                       input int elat, input string tag);
    logic [W+1:0] e;
    int lat;
    @(negedge clock);
    sel = s;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    y_i = y;
    x_i = x;
    in_valid = 1'b1;
    exp_q.push_back({ez, es, ed});
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    y_i = 16'($urandom_range(0, 65535));
    x_i = 16'($urandom_range(0, 65535));
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    e = exp_q.pop_front();
    chk({tag, "_delta"}, 32'(delta), 32'(e[W-1:0]));
    chk({tag, "_sat"}, 32'(sat), 32'(e[W]));
    chk({tag, "_div0"}, 32'(div0), 32'(e[W+1]));
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic retire(input string tag);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  task automatic txn(input bit s, input logic [15:0] y, input logic [15:0] x,
                     input logic [W-1:0] ed, input bit es, input bit ez,
                     input int elat, input string tag);
    issue(s, y, x, ed, es, ez, elat, tag);
    retire(tag);
  endtask

  initial begin
    logic [W-1:0] held;
    rst_n = 1'b0;
    sel = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x_i = '0;
    y_i = '0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_delta", 32'(delta), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    rst_n = 1'b1;

    // Unsigned instance
    txn(1'b0, 16'd48,    16'd16, 12'h030, 1'b0, 1'b0, 21, "u_48_16");
    txn(1'b0, 16'd1,     16'd3,  12'h005, 1'b0, 1'b0, 21, "u_1_3");
    txn(1'b0, 16'hFFFF,  16'd1,  12'hFFF, 1'b1, 1'b0, 21, "u_sat");
    txn(1'b0, 16'd5,     16'd0,  12'hFFF, 1'b1, 1'b1, 1,  "u_div0");
    txn(1'b0, 16'd0,     16'd0,  12'h000, 1'b0, 1'b1, 1,  "u_div0_y0");
    txn(1'b0, 16'd4095,  16'd16, 12'hFFF, 1'b0, 1'b0, 21, "u_edge_max");
    txn(1'b0, 16'd4096,  16'd16, 12'hFFF, 1'b1, 1'b0, 21, "u_edge_ovf");

    // Backpressure: 1600/7 = 228.57 -> 0x0E4
    issue(1'b0, 16'd100, 16'd7, 12'h0E4, 1'b0, 1'b0, 21, "bp");
    held = delta;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      in_valid = i[0];
      y_i = 16'($urandom_range(1, 65535));
      x_i = 16'($urandom_range(1, 65535));
      #1;
      chk("bp_delta_hold", 32'(delta), 32'(held));
      chk("bp_sat_hold", 32'(sat), 32'd0);
      chk("bp_div0_hold", 32'(div0), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    retire("bp");
    chk("bp_state_idle", 32'(state), 32'd0);
    repeat (3) @(negedge clock);
    chk("bp_no_ghost", 32'(out_valid), 32'd0);

    // Signed instance
    txn(1'b1, 16'hFFD0, 16'd16, 12'hFD0, 1'b0, 1'b0, 21, "s_neg48_16");
    txn(1'b1, 16'h8000, 16'd1,  12'h801, 1'b1, 1'b0, 21, "s_min_sat");
    txn(1'b1, 16'd48,   16'd16, 12'h030, 1'b0, 1'b0, 21, "s_pos48");
    txn(1'b1, 16'hFFFF, 16'd3,  12'hFFB, 1'b0, 1'b0, 21, "s_trunc");
    txn(1'b1, 16'hFFFB, 16'd0,  12'h801, 1'b1, 1'b1, 1,  "s_div0_neg");
    txn(1'b1, 16'd0,    16'd7,  12'h000, 1'b0, 1'b0, 21, "s_zero");
    txn(1'b1, 16'd2048, 16'd16, 12'h7FF, 1'b1, 1'b0, 21, "s_edge_ovf");

    // Asynchronous reset at CALC iteration 7 of the unsigned instance
    @(negedge clock);
    sel = 1'b0;
    y_i = 16'd48;
    x_i = 16'd16;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (7) @(posedge clock);
    #2;
    chk("arst_pre_calc", 32'(state), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_delta", 32'(delta), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    txn(1'b0, 16'd100, 16'd7, 12'h0E4, 1'b0, 1'b0, 21, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
